// File: rtl/mips_io_unit.sv
// mips_io_unit: memory-mapped LED/switch port, display FIFO, periodic timer and sticky status register for the MIPS core.
module mips_io_unit #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int LED_W      = 8,
    parameter int SW_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       IOWriteData,
    input  logic [3:0]        IOAddr,
    input  logic              IOWriteEn,
    output logic [31:0]       IOReadData,
    input  logic [SW_W-1:0]   Switches,
    output logic [LED_W-1:0]  Leds,
    output logic [DATA_W-1:0] DispData,
    output logic              DispValid,
    input  logic              DispReady,
    output logic              TimerIrq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [LED_W-1:0]  leds_q, leds_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d, exp_q, exp_d;
    logic [31:0]       reload_q, reload_d, tcnt_q, tcnt_d;
    logic [1:0]        sel;
    logic              wr_led, wr_fifo, wr_tmr, wr_stat;
    logic              empty, full, pop, push, ovf_set, exp_set;
    logic              unused_addr;

    assign unused_addr = &{1'b0, IOAddr[1:0]};

    always_comb begin
        sel       = IOAddr[3:2];
        wr_led    = IOWriteEn && sel == 2'd0;
        wr_fifo   = IOWriteEn && sel == 2'd1;
        wr_tmr    = IOWriteEn && sel == 2'd2;
        wr_stat   = IOWriteEn && sel == 2'd3;
        empty     = cnt_q == '0;
        full      = cnt_q == DEPTH_C;
        pop       = !empty && DispReady;
        // a pop frees the slot in the same cycle, so a full FIFO still accepts
        push      = wr_fifo && (!full || pop);
        ovf_set   = wr_fifo && full && !pop;
        exp_set   = !wr_tmr && reload_q != '0 && tcnt_q <= 32'd1;
        leds_d    = wr_led ? IOWriteData[LED_W-1:0] : leds_q;
        sw_meta_d = Switches;
        sw_sync_d = sw_meta_q;
        mem_d     = mem_q;
        if (push)
            mem_d[wr_ptr_q] = IOWriteData[DATA_W-1:0];
        wr_ptr_d  = wr_ptr_q + AW'(push);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        reload_d  = wr_tmr ? IOWriteData : reload_q;
        tcnt_d    = wr_tmr ? IOWriteData :
                    reload_q == '0 ? tcnt_q :
                    exp_set ? reload_q : tcnt_q - 32'd1;
        // a flag being set wins over a simultaneous clear
        ovf_d     = ovf_set || (ovf_q && !(wr_stat && IOWriteData[1]));
        exp_d     = exp_set || (exp_q && !(wr_stat && IOWriteData[0]));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            leds_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            exp_q     <= 1'b0;
            reload_q  <= '0;
            tcnt_q    <= '0;
        end else begin
            leds_q    <= leds_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            exp_q     <= exp_d;
            reload_q  <= reload_d;
            tcnt_q    <= tcnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_comb begin
        IOReadData = sel == 2'd0 ? 32'(sw_sync_q) :
                     sel == 2'd1 ? {16'b0, 8'(cnt_q), 5'b0, ovf_q, full, empty} :
                     sel == 2'd2 ? tcnt_q : {30'b0, ovf_q, exp_q};
        Leds       = leds_q;
        DispValid  = !empty;
        DispData   = empty ? '0 : mem_q[rd_ptr_q];
        TimerIrq   = exp_q;
    end
endmodule

// File: tb/tb_mips_io_unit.sv
// tb_mips_io_unit: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based reference model of the I/O unit.
module tb_mips_io_unit;
    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] IOWriteData = '0;
    logic [3:0]  IOAddr = '0;
    logic        IOWriteEn = 1'b0;
    logic [31:0] IOReadData;
    logic [7:0]  Switches = '0;
    logic [7:0]  Leds;
    logic [7:0]  DispData;
    logic        DispValid;
    logic        DispReady = 1'b0;
    logic        TimerIrq;
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    mips_io_unit #(.FIFO_DEPTH(DEPTH), .DATA_W(8), .LED_W(8), .SW_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .IOWriteData(IOWriteData), .IOAddr(IOAddr),
        .IOWriteEn(IOWriteEn), .IOReadData(IOReadData), .Switches(Switches),
        .Leds(Leds), .DispData(DispData), .DispValid(DispValid),
        .DispReady(DispReady), .TimerIrq(TimerIrq)
    );

    logic [7:0]  q[$];
    bit          m_ovf, m_exp;
    logic [31:0] m_reload, m_cnt;
    logic [7:0]  m_leds, m_sw1, m_sw2;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_exp = 0; m_reload = 0; m_cnt = 0; m_leds = 0; m_sw1 = 0; m_sw2 = 0;
    endtask

    task automatic model_step();
        logic [1:0] sel;
        bit pop, full;
        sel  = IOAddr[3:2];
        pop  = q.size() != 0 && DispReady;
        full = q.size() == DEPTH;
        if (IOWriteEn && sel == 2'd3) begin
            if (IOWriteData[0]) m_exp = 0;
            if (IOWriteData[1]) m_ovf = 0;
        end
        if (pop) void'(q.pop_front());
        if (IOWriteEn && sel == 2'd1) begin
            if (!full || pop) q.push_back(IOWriteData[7:0]);
            else m_ovf = 1;
        end
        if (IOWriteEn && sel == 2'd2) begin
            m_reload = IOWriteData;
            m_cnt = IOWriteData;
        end else if (m_reload != 0) begin
            if (m_cnt <= 1) begin
                m_cnt = m_reload;
                m_exp = 1;
            end else m_cnt = m_cnt - 1;
        end
        if (IOWriteEn && sel == 2'd0) m_leds = IOWriteData[7:0];
        m_sw2 = m_sw1;
        m_sw1 = Switches;
    endtask

    function automatic logic [31:0] model_read();
        case (IOAddr[3:2])
            2'd0: return {24'b0, m_sw2};
            2'd1: return {16'b0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
            2'd2: return m_cnt;
            default: return {30'b0, m_ovf, m_exp};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_leds", Leds, m_leds);
        chk("m_valid", DispValid, q.size() != 0);
        chk("m_data", DispData, q.size() != 0 ? q[0] : 8'h00);
        chk("m_irq", TimerIrq, m_exp);
        chk("m_rdata", IOReadData, model_read());
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        IOWriteEn = 1; IOAddr = a; IOWriteData = d;
        tick();
        IOWriteEn = 0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic [7:0]  sw;
        logic [31:0] e_rd;
        logic [7:0]  e_leds;
        logic        e_valid;
        logic [7:0]  e_data;
    } vec_t;

    function automatic vec_t mk(logic we, logic [3:0] a, logic [31:0] wd, logic rdy, logic [7:0] sw,
                                logic [31:0] rd, logic [7:0] l, logic v, logic [7:0] d);
        vec_t t;
        t.we = we; t.addr = a; t.wd = wd; t.rdy = rdy; t.sw = sw;
        t.e_rd = rd; t.e_leds = l; t.e_valid = v; t.e_data = d;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        vt.push_back(mk(1, 4'h0, 32'hA5, 0, 8'h00, 32'h0, 8'hA5, 0, 8'h00));
        vt.push_back(mk(0, 4'h0, 32'h0, 0, 8'h3C, 32'h0, 8'hA5, 0, 8'h00));
        vt.push_back(mk(0, 4'h0, 32'h0, 0, 8'h3C, 32'h3C, 8'hA5, 0, 8'h00));
        for (int k = 1; k <= 8; k++)
            vt.push_back(mk(1, 4'h4, 32'h10 + k, 0, 8'h3C, (k << 8) | (k == 8 ? 2 : 0), 8'hA5, 1, 8'h11));
        vt.push_back(mk(1, 4'h4, 32'h99, 0, 8'h3C, 32'h806, 8'hA5, 1, 8'h11));
        vt.push_back(mk(0, 4'h4, 32'h0, 0, 8'h3C, 32'h806, 8'hA5, 1, 8'h11));

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        IOAddr = 4'h4;
        #1;
        chk("rst_leds", Leds, 0);
        chk("rst_valid", DispValid, 0);
        chk("rst_data", DispData, 0);
        chk("rst_irq", TimerIrq, 0);
        chk("rst_status", IOReadData, 32'h1);
        @(negedge CLK);
        RESET = 1;

        foreach (vt[i]) begin
            IOWriteEn = vt[i].we; IOAddr = vt[i].addr; IOWriteData = vt[i].wd;
            DispReady = vt[i].rdy; Switches = vt[i].sw;
            tick();
            chk($sformatf("vec%0d_rd", i), IOReadData, vt[i].e_rd);
            chk($sformatf("vec%0d_leds", i), Leds, vt[i].e_leds);
            chk($sformatf("vec%0d_valid", i), DispValid, vt[i].e_valid);
            chk($sformatf("vec%0d_data", i), DispData, vt[i].e_data);
        end

        IOWriteEn = 0; IOAddr = 4'h4; DispReady = 1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", DispData, 32'h11 + i);
            chk("drain_valid", DispValid, 1);
            tick();
        end
        chk("drain_empty", DispValid, 0);
        chk("drain_status", IOReadData, 32'h5);
        wr(4'hC, 32'h2);
        IOAddr = 4'h4;
        #1;
        chk("ovf_clr_status", IOReadData, 32'h1);

        DispReady = 0;
        for (int k = 0; k < 8; k++) wr(4'h4, 32'h21 + k);
        DispReady = 1;
        IOWriteEn = 1; IOAddr = 4'h4; IOWriteData = 32'h77;
        tick();
        chk("fullpop_status", IOReadData, 32'h802);
        IOWriteEn = 0;
        for (int i = 0; i < 8; i++) begin
            chk("fullpop_data", DispData, i < 7 ? 32'h22 + i : 32'h77);
            tick();
        end
        chk("fullpop_empty", DispValid, 0);
        DispReady = 0;

        wr(4'h8, 32'd5);
        IOAddr = 4'h8;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("tmr_irq", TimerIrq, i == 5);
            chk("tmr_cnt", IOReadData, i == 5 ? 5 : 5 - i);
        end
        wr(4'hC, 32'h1);
        chk("tmr_clr", TimerIrq, 0);
        IOAddr = 4'h8;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("tmr_rearm", TimerIrq, i == 4);
        end
        wr(4'h8, 32'd0);
        wr(4'hC, 32'h1);

        for (int k = 0; k < 4; k++) wr(4'h4, 32'hA1 + k);
        wr(4'h0, 32'h5A);
        wr(4'h8, 32'd3);
        repeat (3) tick();
        DispReady = 1;
        tick();
        chk("pre_rst_valid", DispValid, 1);
        chk("pre_rst_irq", TimerIrq, 1);
        chk("pre_rst_leds", Leds, 8'h5A);
        IOAddr = 4'h4;
        #1;
        chk("pre_rst_status", IOReadData, 32'h300);
        #1;
        RESET = 0;
        #1;
        chk("async_rst_valid", DispValid, 0);
        chk("async_rst_irq", TimerIrq, 0);
        chk("async_rst_leds", Leds, 0);
        chk("async_rst_data", DispData, 0);
        model_reset();
        DispReady = 0;
        @(negedge CLK);
        RESET = 1;
        #1;
        chk("post_rst_status", IOReadData, 32'h1);
        repeat (3) tick();

        for (int i = 0; i < 600; i++) begin
            IOWriteEn = 1'($urandom_range(0, 1));
            IOAddr = 4'($urandom);
            IOWriteData = IOAddr[3:2] == 2'd2 ? $urandom_range(0, 7) : $urandom;
            DispReady = i < 300 ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) Switches = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
